wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin write-back arbiter for the convolution/pooling engine. It collects results from up to NUM_REQ compute units (CMACs or pooling accumulators), grants one result per cycle, and forwards it with its source index to a single write-back FIFO. It counts delivered results against a programmed total and pulses `done` when the layer's output burst is complete. It sits between the engine's result buses and the write-back FIFO feeding the CSB/DMA path.

## Interface
- NUM_REQ, 16: number of requesters; 2 ≤ NUM_REQ ≤ 2^IDX_W.
- DATA_W, 16: result width (fp16).
- IDX_W, 4: width of the source-index field.
- CNT_W, 32: width of the result counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; arms the arbiter for a new burst.
- total_num  in  CNT_W  number of results expected; sampled on `start`.
- req  in  NUM_REQ  per-unit result-valid; held until acked.
- req_data  in  NUM_REQ*DATA_W  result of unit i at bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot, combinational; unit i's result is consumed this cycle.
- wr_afull  in  1  FIFO almost-full; high when ≤1 free entry.
- wr_en  out  1  registered FIFO write strobe.
- wr_data  out  DATA_W  registered granted result.
- wr_idx  out  IDX_W  registered source index of `wr_data`.
- busy  out  1  high in BUSY.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start` with total_num ≠ 0: load remaining = total_num, set ptr = 0, go to BUSY.
  - `start` with total_num = 0: go to DONE directly; no writes occur.
  - `req` is ignored and `ack` = 0.
- BUSY:
  - Grant condition: any `req` bit set and wr_afull = 0.
  - Winner: the first set `req` bit searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - On grant:
    - ack[winner] = 1.
    - Next cycle: wr_en = 1, wr_data = winner's data, wr_idx = winner.
    - ptr ← winner+1, wrapping to 0 after NUM_REQ-1.
    - remaining ← remaining-1.
  - A grant with remaining = 1 moves to DONE.
  - `start` is ignored in BUSY.
- DONE: lasts exactly one cycle with done = 1, then IDLE. A `start` in DONE is ignored.
- No grant (no request, or wr_afull = 1): ptr, remaining and state hold; wr_en = 0 next cycle.
- Counter arithmetic: unsigned CNT_W-bit; never decrements below 1 in BUSY; no wrap.
- Requests arriving after the count is exhausted are left un-acked. Upstream owns over-production.

## Timing
- Reset values: state = IDLE, ptr = 0, remaining = 0, wr_en = 0, wr_data = 0, wr_idx = 0, busy = 0, done = 0.
- `ack` is 0 during reset.
- Reset mid-burst: all of the above are restored immediately (asynchronous). A pending write is dropped; no partial `done`.
- Latency: req/grant in cycle N gives wr_en in cycle N+1. Throughput is 1 result/cycle while wr_afull = 0.
- `done` coincides with the wr_en of the final result: the cycle after the last grant.
- For a zero-count start, `done` is the cycle after `start`.
- wr_afull is sampled in the grant cycle. Because the write lands one cycle later, one in-flight write is always covered by the ≤1-free-entry definition.
- Unit i must see ack[i] = 1 at a clock edge to retire its result. It may present a new result on `req` the following cycle.
- busy is high from the cycle after `start` through the last grant cycle; low in DONE.

## Test plan
- Basic fill: total_num = 16, all 16 req high from BUSY entry.
  - Acks go 0,1,…,15 in consecutive cycles.
  - wr_idx = 0..15 on 16 consecutive wr_en cycles.
  - done pulses with wr_idx = 15.
- Fairness: req[3] and req[9] held continuously, total_num = 6.
  - Grant order 3,9,3,9,3,9.
  - Pointer wrap: req[15] and req[0] only, with ptr at 15, give grant order 15,0.
- Backpressure: total_num = 4, all req high, wr_afull = 1 for cycles 2–4 of BUSY.
  - No ack and no wr_en in the cycles following.
  - Exactly 4 writes total; done after the 4th.
- Zero count and ignored inputs:
  - start with total_num = 0: done the next cycle, zero wr_en.
  - req high while IDLE: ack = 0.
  - start during BUSY: counter unchanged.
- Reset mid-burst: total_num = 16, assert rst after 5 grants.
  - All outputs at reset values the same cycle; no done.
  - A new start with total_num = 2 completes with wr_idx = 0,1.
- Data integrity: req_data[i] = 16'h3C00 + i.
  - Each wr_data equals 16'h3C00 + wr_idx.
  - Randomized sparse req over total_num = 64 delivers exactly 64 writes.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result-producing compute units, the write-back FIFO and wb_arbiter.
// Ports: start/total_num arm a burst; req/req_data/ack form the per-unit result handshake;
//        wr_afull/wr_en/wr_data/wr_idx form the FIFO write side; busy/done report burst status.
interface wb_arbiter_if #(
    parameter int NUM_REQ = 16,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 32
) ();
    logic                        start;
    logic [CNT_W-1:0]            total_num;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          ack;
    logic                        wr_afull;
    logic                        wr_en;
    logic [DATA_W-1:0]           wr_data;
    logic [IDX_W-1:0]            wr_idx;
    logic                        busy;
    logic                        done;

    // Engine/FIFO side: drives control, requests and FIFO status.
    modport master (
        output start, total_num, req, req_data, wr_afull,
        input  ack, wr_en, wr_data, wr_idx, busy, done
    );

    // Arbiter side.
    modport slave (
        input  start, total_num, req, req_data, wr_afull,
        output ack, wr_en, wr_data, wr_idx, busy, done
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: grants one compute-unit result per cycle to the write-back FIFO
// and pulses done once the programmed number of results has been delivered.
// Ports: clk, rst (async, active-high) and the wb_arbiter_if slave modport (ack is combinational,
//        wr_en/wr_data/wr_idx are registered one cycle after the grant; wr_afull stalls grants).
module wb_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [DATA_W-1:0]  win_data;
    logic               grant;

    logic               wr_en_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [IDX_W-1:0]   wr_idx_q;

    // Rotating priority without a rotator: first scan units at or above ptr,
    // then wrap around to the units below it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i] && (IDX_W'(i) >= ptr)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i] && (IDX_W'(i) < ptr)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // wr_afull already reserves room for the write landing next cycle.
    assign grant = (state == BUSY) && found && !bus.wr_afull;

    always_comb begin
        bus.ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.ack[i] = grant && (win == IDX_W'(i));
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.total_num == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = BUSY;
                        remaining_nxt = bus.total_num;
                        ptr_nxt       = '0;
                    end
                end
            end
            BUSY: begin
                if (grant) begin
                    ptr_nxt       = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
                    // remaining is at least 1 here, so this never wraps.
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            wr_en_q   <= grant;
            if (grant) begin
                wr_data_q <= win_data;
                wr_idx_q  <= win;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_idx  = wr_idx_q;
    assign bus.busy    = (state == BUSY);
    // Entering DONE coincides with the final write, so done lines up with its wr_en.
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int NUM = 16;
    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int CW  = 32;

    typedef struct {
        int          idx;
        logic [15:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_REQ(NUM), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)) bus ();

    wb_arbiter #(.NUM_REQ(NUM), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model state: 0 idle, 1 busy, 2 done.
    int     m_state;
    int     m_ptr;
    longint m_rem;
    wr_t    expq[$];
    int     got[$];
    int     nwr;
    int     last_done_idx;
    int     bp_stray;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_rem   = 0;
        expq.delete();
    endtask

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic step(output bit g, output int w);
        wr_t e;
        g = 1'b0;
        w = 0;
        #1;
        if (m_state == 1 && !bus.wr_afull) begin
            for (int k = 0; k < NUM; k++) begin
                int j;
                j = (m_ptr + k) % NUM;
                if (!g && bus.req[j]) begin
                    g = 1'b1;
                    w = j;
                end
            end
        end
        check("ack", bus.ack, g ? (64'd1 << w) : 64'd0);
        if (g) expq.push_back('{w, 16'h3C00 + 16'(w)});
        case (m_state)
            0: if (bus.start) begin
                   if (bus.total_num == 0) m_state = 2;
                   else begin
                       m_state = 1;
                       m_rem   = longint'(bus.total_num);
                       m_ptr   = 0;
                   end
               end
            1: if (g) begin
                   m_ptr = (w + 1) % NUM;
                   if (m_rem == 1) m_state = 2;
                   m_rem--;
               end
            default: m_state = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
        check("wr_en", bus.wr_en, g);
        check("busy", bus.busy, m_state == 1);
        check("done", bus.done, m_state == 2);
        if (bus.wr_en) begin
            got.push_back(int'(bus.wr_idx));
            nwr++;
            check("wr_data_vs_idx", bus.wr_data, 16'h3C00 + 16'(bus.wr_idx));
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("wr_idx", bus.wr_idx, e.idx);
                check("wr_data", bus.wr_data, e.dat);
            end
        end else if (expq.size() > 0) begin
            expq.delete();
        end
        if (bus.done) last_done_idx = bus.wr_en ? int'(bus.wr_idx) : -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_wr_idx"}, bus.wr_idx, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_ack"}, bus.ack, 0);
    endtask

    // mode: 0 all req, 1 units 3/9 + stray start, 2 pointer wrap, 3 backpressure,
    //       4 random sparse, 5 all req with reset after 5 grants
    task automatic burst(input longint total, input int mode, input int bound);
        bit              g;
        int              w;
        int              c;
        int              grants;
        logic [NUM-1:0]  pend;
        got.delete();
        nwr           = 0;
        grants        = 0;
        pend          = '0;
        last_done_idx = -2;
        bp_stray      = 0;
        bus.start     = 1'b1;
        bus.total_num = CW'(total);
        bus.req       = '0;
        bus.wr_afull  = 1'b0;
        step(g, w);
        c = 0;
        while (m_state != 0 && c < bound) begin
            bus.start    = 1'b0;
            bus.wr_afull = 1'b0;
            case (mode)
                0, 5: bus.req = '1;
                1: begin
                    bus.req = 16'h0208;
                    if (c == 2) begin
                        bus.start     = 1'b1;
                        bus.total_num = 32'd100;
                    end
                end
                2: bus.req = (c == 0) ? 16'h4000 : 16'h8001;
                3: begin
                    bus.req      = '1;
                    bus.wr_afull = (c >= 1 && c <= 3);
                end
                default: begin
                    for (int i = 0; i < NUM; i++)
                        if (!pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b1;
                    bus.req = pend;
                end
            endcase
            step(g, w);
            if (mode == 3 && c >= 1 && c <= 3 && bus.wr_en) bp_stray++;
            if (g) begin
                grants++;
                pend[w] = 1'b0;
            end
            c++;
            if (mode == 5 && grants == 5) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                model_reset();
                bus.req = '0;
                @(negedge clk);
                check("midrst_no_done", bus.done, 0);
                rst = 1'b0;
                break;
            end
        end
        bus.start    = 1'b0;
        bus.req      = '0;
        bus.wr_afull = 1'b0;
        if (mode != 5) check("burst_timeout", (c < bound) ? 1 : 0, 1);
    endtask

    initial begin
        bit g;
        int w;
        int exp_fair[6] = '{3, 9, 3, 9, 3, 9};
        int exp_wrap[3] = '{14, 15, 0};

        bus.start     = 1'b0;
        bus.total_num = '0;
        bus.req       = '0;
        bus.wr_afull  = 1'b0;
        for (int i = 0; i < NUM; i++) bus.req_data[i*DW +: DW] = 16'h3C00 + 16'(i);
        rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        bus.req   = '1;
        bus.start = 1'b1;
        bus.total_num = 32'd5;
        @(negedge clk);
        check_reset_outputs("reset");
        bus.req   = '0;
        bus.start = 1'b0;
        rst = 1'b0;

        // Requests while idle are ignored.
        nwr = 0;
        bus.req = '1;
        repeat (3) step(g, w);
        bus.req = '0;
        check("idle_no_writes", nwr, 0);

        // Zero-count start: done next cycle, no writes.
        burst(0, 0, 4);
        check("zero_done_seen", last_done_idx, -1);
        step(g, w);
        check("zero_writes", nwr, 0);

        // Basic fill.
        burst(16, 0, 40);
        check("fill_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("fill_order", got[i], i);
        check("fill_done_idx", last_done_idx, 15);

        // Fairness between two held requesters; stray start mid-burst.
        burst(6, 1, 40);
        check("fair_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("fair_order", got[i], exp_fair[i]);

        // Pointer wrap from 15 to 0.
        burst(3, 2, 20);
        check("wrap_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("wrap_order", got[i], exp_wrap[i]);

        // Backpressure.
        burst(4, 3, 30);
        check("bp_count", nwr, 4);
        check("bp_no_wr_while_full", bp_stray, 0);
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], i);
        check("bp_done_idx", last_done_idx, 3);

        // Reset mid-burst, then a fresh short burst.
        burst(16, 5, 40);
        check("midrst_writes_before", nwr, 5);
        burst(2, 0, 20);
        check("post_rst_count", got.size(), 2);
        for (int i = 0; i < 2 && i < got.size(); i++) check("post_rst_order", got[i], i);

        // Random sparse requests.
        burst(64, 4, 3000);
        check("rand_count", nwr, 64);
        step(g, w);
        check("rand_no_extra", nwr, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
